// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, parity-mode encodings
// and the default frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [1:0] PARITY_NONE  = 2'b00;
    localparam logic [1:0] PARITY_ODD   = 2'b01;
    localparam logic [1:0] PARITY_EVEN  = 2'b10;
    localparam logic [1:0] PARITY_NONE2 = 2'b11;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;

    // Only odd and even modes carry a parity bit on the line.
    function automatic logic parity_enabled(input logic [1:0] pt);
        case (pt)
            PARITY_ODD, PARITY_EVEN:   return 1'b1;
            PARITY_NONE, PARITY_NONE2: return 1'b0;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sipo_rx_if.sv
// Bundle of the receiver's line-side inputs and frame-result outputs.
// The master side drives the line and tick; the slave side is the receiver.
interface sipo_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 sample_tick;
    logic                 data_rx;
    logic [1:0]           parity_type;
    logic [DATA_BITS-1:0] data_out;
    logic                 active_flag;
    logic                 done_flag;
    logic                 parity_error;
    logic                 framing_error;

    modport master (
        output sample_tick, data_rx, parity_type,
        input  data_out, active_flag, done_flag, parity_error, framing_error
    );

    modport slave (
        input  sample_tick, data_rx, parity_type,
        output data_out, active_flag, done_flag, parity_error, framing_error
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the
// idle (high) level so reset never looks like a start bit.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/sipo_rx.sv
// Oversampled UART serial-in/parallel-out receiver with optional parity.
// Define SIPO_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around mid-bit.
module sipo_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
    input logic      clk,
    input logic      reset,
    sipo_rx_if.slave bus
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] HALF_M1   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] HALF      = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [1:0]           ptype_q, ptype_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 wait_high_q, wait_high_d;
    logic                 rx_s;
    logic                 bit_val;
    logic                 in_bit;

`ifdef SIPO_RX_MAJORITY_EN
    localparam logic [TICK_W-1:0] HALF_P1 = TICK_W'(OVERSAMPLE / 2 + 1);
    logic [2:0] samp_q, samp_d;
    assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
`else
    logic samp_q, samp_d;
    assign bit_val = samp_q;
`endif

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.data_rx),
        .q     (rx_s)
    );

    assign in_bit = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);

    // Bit values are captured around mid-bit and consumed later at the
    // sample point (last tick of the bit window), which drives state advance.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        ptype_d     = ptype_q;
        active_d    = active_q;
        done_d      = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        wait_high_d = wait_high_q;
        samp_d      = samp_q;

        if (bus.sample_tick) begin
`ifdef SIPO_RX_MAJORITY_EN
            if (in_bit && tick_q == HALF_M1) samp_d[0] = rx_s;
            if (in_bit && tick_q == HALF)    samp_d[1] = rx_s;
            if (in_bit && tick_q == HALF_P1) samp_d[2] = rx_s;
`else
            if (in_bit && tick_q == HALF)    samp_d = rx_s;
`endif
            unique case (state_q)
                IDLE: begin
                    if (rx_s) begin
                        wait_high_d = 1'b0;
                    end else if (!wait_high_q) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == HALF_M1) begin
                        if (!rx_s) begin
                            state_d  = DATA;
                            tick_d   = '0;
                            bit_d    = '0;
                            active_d = 1'b1;
                            perr_d   = 1'b0;
                            ferr_d   = 1'b0;
                            ptype_d  = bus.parity_type;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == LAST_TICK) begin
                        tick_d  = '0;
                        shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                        if (bit_q == LAST_BIT) begin
                            bit_d   = '0;
                            state_d = parity_enabled(ptype_q) ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick_q == LAST_TICK) begin
                        tick_d  = '0;
                        state_d = STOP;
                        perr_d  = (ptype_q == PARITY_ODD) ? ~(^shift_q ^ bit_val)
                                                          :  (^shift_q ^ bit_val);
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    // A low stop bit may be the start of a break, so arm the
                    // wait-for-high guard before looking for another start.
                    if (tick_q == LAST_TICK) begin
                        tick_d      = '0;
                        state_d     = IDLE;
                        ferr_d      = ~bit_val;
                        wait_high_d = ~bit_val;
                        data_d      = shift_q;
                        done_d      = 1'b1;
                        active_d    = 1'b0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Single state register for the whole receiver.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            ptype_q     <= PARITY_NONE;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            wait_high_q <= 1'b0;
            samp_q      <= '1;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            ptype_q     <= ptype_d;
            active_q    <= active_d;
            done_q      <= done_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            wait_high_q <= wait_high_d;
            samp_q      <= samp_d;
        end
    end

    assign bus.data_out      = data_q;
    assign bus.active_flag   = active_q;
    assign bus.done_flag     = done_q;
    assign bus.parity_error  = perr_q;
    assign bus.framing_error = ferr_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: directed frames push expected results,
// a monitor pops and compares on every done_flag pulse.
module tb_sipo_rx;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   active_cycles;
    int   act_snap;
    exp_t exp_q[$];

    sipo_rx_if #(.DATA_BITS(8)) bus ();

    sipo_rx #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One sample_tick every four clocks, so the synchroniser settles between ticks.
    task automatic tick_n(input int n);
        repeat (n) begin
            repeat (3) @(negedge clk);
            bus.sample_tick = 1'b1;
            @(negedge clk);
            bus.sample_tick = 1'b0;
        end
    endtask

    task automatic push_exp(input logic [7:0] data, input logic perr, input logic ferr);
        exp_t e;
        e.data = data;
        e.perr = perr;
        e.ferr = ferr;
        exp_q.push_back(e);
    endtask

    // Drives one frame, 16 ticks per bit; glitch_bit inverts that bit for its second tick.
    task automatic applyStimulus(input logic [7:0] data, input logic [1:0] ptype, input logic pbit,
                                 input logic stop_val, input int stop_ticks, input int glitch_bit);
        logic [10:0] bits;
        int          nbits;
        bits    = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        nbits = 9;
        if (ptype == 2'b01 || ptype == 2'b10) begin
            bits[nbits] = pbit;
            nbits++;
        end
        bits[nbits] = stop_val;
        nbits++;
        bus.parity_type = ptype;
        for (int i = 0; i < nbits; i++) begin
            bus.data_rx = bits[i];
            if (i == nbits - 1) begin
                tick_n(stop_ticks);
            end else if (i == glitch_bit) begin
                tick_n(1);
                bus.data_rx = ~bits[i];
                tick_n(1);
                bus.data_rx = bits[i];
                tick_n(14);
            end else begin
                tick_n(16);
            end
        end
    endtask

    // Monitor: every done_flag pulse must match the oldest expected frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.active_flag) active_cycles++;
            if (!reset && bus.done_flag) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_done: got done_flag with data_out 0x%0h, expected no frame", bus.data_out);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("data_out", 32'(bus.data_out), 32'(e.data));
                    checkOutput("parity_error", 32'(bus.parity_error), 32'(e.perr));
                    checkOutput("framing_error", 32'(bus.framing_error), 32'(e.ferr));
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors         = 0;
        miscompares     = 0;
        active_cycles   = 0;
        reset           = 1'b1;
        bus.sample_tick = 1'b0;
        bus.data_rx     = 1'b1;
        bus.parity_type = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tick_n(4);
        checkOutput("rst_data_out", 32'(bus.data_out), 32'h0);
        checkOutput("rst_active", 32'(bus.active_flag), 32'h0);
        checkOutput("rst_done", 32'(bus.done_flag), 32'h0);
        checkOutput("rst_perr", 32'(bus.parity_error), 32'h0);
        checkOutput("rst_ferr", 32'(bus.framing_error), 32'h0);

        $display("[TB] frame 0x4A, no parity");
        push_exp(8'h4A, 1'b0, 1'b0);
        act_snap = active_cycles;
        applyStimulus(8'h4A, 2'b00, 1'b0, 1'b1, 16, -1);
        checkOutput("active_during_frame", 32'(active_cycles > act_snap), 32'h1);
        tick_n(8);

        $display("[TB] frame 0x5A, odd parity, good and bad parity bit");
        push_exp(8'h5A, 1'b0, 1'b0);
        applyStimulus(8'h5A, 2'b01, 1'b1, 1'b1, 16, -1);
        tick_n(8);
        push_exp(8'h5A, 1'b1, 1'b0);
        applyStimulus(8'h5A, 2'b01, 1'b0, 1'b1, 16, -1);
        tick_n(8);

        $display("[TB] frame 0x4A, even parity, stop low then break");
        push_exp(8'h4A, 1'b0, 1'b1);
        applyStimulus(8'h4A, 2'b10, 1'b1, 1'b0, 16, -1);
        act_snap = active_cycles;
        bus.data_rx = 1'b0;
        tick_n(40);
        checkOutput("break_no_start", 32'(active_cycles - act_snap), 32'h0);
        bus.data_rx = 1'b1;
        tick_n(20);

        $display("[TB] 5-tick glitch on idle line");
        act_snap = active_cycles;
        bus.data_rx = 1'b0;
        tick_n(5);
        bus.data_rx = 1'b1;
        tick_n(30);
        checkOutput("glitch_no_active", 32'(active_cycles - act_snap), 32'h0);

        $display("[TB] back-to-back frames 0x81, 0x7E");
        push_exp(8'h81, 1'b0, 1'b0);
        applyStimulus(8'h81, 2'b00, 1'b0, 1'b1, 8, -1);
        push_exp(8'h7E, 1'b0, 1'b0);
        applyStimulus(8'h7E, 2'b00, 1'b0, 1'b1, 16, -1);
        tick_n(8);

        $display("[TB] reset during bit 4, then frame 0xA5");
        bus.parity_type = 2'b00;
        bus.data_rx = 1'b0; tick_n(16);
        bus.data_rx = 1'b1; tick_n(16);
        bus.data_rx = 1'b1; tick_n(16);
        bus.data_rx = 1'b0; tick_n(16);
        bus.data_rx = 1'b0; tick_n(16);
        bus.data_rx = 1'b1; tick_n(8);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_rst_data_out", 32'(bus.data_out), 32'h0);
        checkOutput("mid_rst_active", 32'(bus.active_flag), 32'h0);
        reset = 1'b0;
        bus.data_rx = 1'b1;
        tick_n(20);
        push_exp(8'hA5, 1'b0, 1'b0);
        applyStimulus(8'hA5, 2'b00, 1'b0, 1'b1, 16, -1);
        tick_n(8);

`ifdef SIPO_RX_MAJORITY_EN
        $display("[TB] frame 0x3C with one-tick glitch in bit 2");
        push_exp(8'h3C, 1'b0, 1'b0);
        applyStimulus(8'h3C, 2'b00, 1'b0, 1'b1, 16, 3);
        tick_n(8);
`endif

        tick_n(4);
        checkOutput("pending_expected", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, sets the sample_tick count per bit period and SHALL be a power of two ≥ 8.
REQ-002 Parameter DATA_BITS, default 8, sets the number of payload bits per frame.
REQ-003 clk  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sample_tick  input  1  one-clk strobe at OVERSAMPLE × baud rate; all bit timing SHALL advance only on cycles where it is high.
REQ-006 data_rx  input  1  serial line; idles high, LSB first, asynchronous to clk.
REQ-007 parity_type  input  2  00 none, 01 odd, 10 even, 11 none; sampled at start-bit confirmation.
REQ-008 data_out  output  DATA_BITS  last received payload; holds its value between frames.
REQ-009 active_flag  output  1  high from start-bit confirmation through the end of the stop bit.
REQ-010 done_flag  output  1  one-clk pulse when a frame completes.
REQ-011 parity_error  output  1  valid with done_flag; high when the parity check fails.
REQ-012 framing_error  output  1  valid with done_flag; high when the stop-bit sample is 0.

Function
REQ-013 data_rx SHALL pass through a 2-flop synchroniser; all logic SHALL use the synchronised value rx_s.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY and STOP, with an internal tick counter tick_cnt and a bit counter bit_cnt.
REQ-015 IDLE: when rx_s is 0, the FSM SHALL go to START with tick_cnt=0.
REQ-016 START: at tick_cnt=OVERSAMPLE/2-1, rx_s=0 SHALL confirm the start bit (active_flag=1, tick_cnt cleared, go to DATA); rx_s=1 SHALL be treated as a false start and return the FSM to IDLE with no flags.
REQ-017 DATA: on each sample point (tick_cnt=OVERSAMPLE-1), the FSM SHALL shift the bit into the shift register LSB-first and increment bit_cnt; after DATA_BITS bits it SHALL go to PARITY if parity_type is 01 or 10, else to STOP.
REQ-018 PARITY: at the sample point, parity_error SHALL be computed as follows: odd mode flags an error when the XOR of data and parity bit is 0; even mode flags an error when it is 1.
REQ-019 STOP: at the sample point, framing_error SHALL be set to ~rx_s, data_out loaded from the shift register, done_flag pulsed, active_flag cleared, and the FSM SHALL return to IDLE in the same cycle.
REQ-020 Latency: done_flag SHALL assert on the clk edge of the mid-stop sample tick, plus the 2-cycle synchroniser delay, relative to line timing.
REQ-021 data_out SHALL update even on a parity or framing error; the error flags SHALL be cleared on the next frame's start confirmation.
REQ-022 In no-parity mode, parity_error SHALL always be 0.
REQ-023 A start edge arriving in the same cycle as done_flag SHALL be detected on the following tick with no frame lost.
REQ-024 A framing error followed by a line held low (break) SHALL NOT start a new frame until rx_s has been high for at least one tick.

Reset
REQ-025 Reset SHALL force the FSM to IDLE, both counters and the shift register to 0, data_out to 0, all flags to 0, and both synchroniser flops to 1.
REQ-026 Reset mid-frame SHALL abort the frame immediately with no done_flag pulse.

Configuration
REQ-027 With SIPO_RX_MAJORITY_EN defined, each bit value SHALL be the 2-of-3 majority of rx_s at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1; the sample point for state advance SHALL be unchanged.
REQ-028 Without SIPO_RX_MAJORITY_EN, each bit value SHALL be the single sample of rx_s at tick OVERSAMPLE/2.

Structure
REQ-029 A shared package uart_pkg SHALL hold the state enum, the PARITY_NONE, PARITY_ODD, PARITY_EVEN and PARITY_NONE2 encodings, and the default OVERSAMPLE and DATA_BITS.
REQ-030 The synchroniser SHALL be the sub-module sync_2ff; all other logic SHALL be flat.

Verification
REQ-031 Frame 0x4A, parity 00, stop bit 1 -> single done_flag, data_out=0x4A, parity_error=0, framing_error=0.
REQ-032 Frame 0x5A, parity 01, parity bit 1 -> data_out=0x5A, parity_error=0; the same frame with parity bit 0 -> parity_error=1.
REQ-033 Frame 0x4A, parity 10, stop bit forced to 0 -> data_out=0x4A, framing_error=1, done_flag pulses once.
REQ-034 A 5-tick low glitch on an idle line -> false start, FSM back in IDLE, no active_flag, no done_flag.
REQ-035 Reset asserted during bit 4 of a frame, then the next frame 0xA5 -> no done_flag for the aborted frame, data_out=0xA5 after the next frame.
REQ-036 With SIPO_RX_MAJORITY_EN defined, a 1-tick inverted glitch at mid-bit of 0x3C -> data_out=0x3C.
